// File: rtl/isa_decode_pkg.sv
// Shared constants and types for the ISA command decoder: register offsets,
// sequencer state encoding and a constant clog2 helper.
package isa_decode_pkg;

  localparam logic [3:0] OFF_TRIG     = 4'h0;
  localparam logic [3:0] OFF_INTERVAL = 4'h4;
  localparam logic [3:0] OFF_MASK     = 4'h8;
  localparam logic [3:0] OFF_WADD     = 4'h0;
  localparam logic [3:0] OFF_OFFSET   = 4'h4;
  localparam logic [3:0] OFF_WCLR     = 4'h8;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/isa_tx_fifo.sv
// Show-ahead FIFO for host-bound TX words; the head is presented while
// non-empty and popped on pop_i, pops when empty and pushes when full are ignored.
module isa_tx_fifo
  import isa_decode_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                    I_rd_clk,
  input  logic                    I_rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        wdata_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    full_o,
  output logic [clog2(DEPTH):0]   count_o
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             empty, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty;
  assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];

  // NOTE: the storage array is deliberately left unreset; only pointers and the
  // occupancy count need a known state, and the head is masked while empty.
  always_ff @(posedge I_rd_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge I_rd_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/isa_decode_mc.sv
// Multi-channel ISA command decoder: registered decode of {addr,data} beats into
// trigger sequencers, a wait accumulator, an offset register and a TX FIFO.
module isa_decode_mc
  import isa_decode_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int WAIT_W     = 32,
  parameter int WAIT_INS   = 24,
  parameter logic [ADDR_W-1:0] BASE_TRIG = 32'h4000_1000,
  parameter logic [ADDR_W-1:0] BASE_WAIT = 32'h4000_2000,
  parameter logic [ADDR_W-1:0] BASE_TX   = 32'h4000_4000
) (
  input  logic                     I_rd_clk,
  input  logic                     I_rst_n,
  input  logic                     I_cmd_valid,
  output logic                     O_cmd_ready,
  input  logic [ADDR_W-1:0]        I_cmd_addr,
  input  logic [DATA_W-1:0]        I_cmd_data,
  output logic [ADDR_W+DATA_W-1:0] O_tx_data,
  output logic                     O_tx_valid,
  input  logic                     I_tx_ready,
  output logic [NUM_CH-1:0]        O_trig,
  output logic [NUM_CH*DATA_W-1:0] O_trig_mask,
  output logic [NUM_CH-1:0]        O_trig_busy,
  output logic [WAIT_W-1:0]        O_wait,
  output logic [DATA_W-1:0]        O_offset,
  output logic [15:0]              O_unmapped
);

  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_W-1:0] INS_MASK = ~({DATA_W{1'b1}} << WAIT_INS);
  localparam logic [DATA_W-1:0] D_ONE    = DATA_W'(1);

  logic                     rdy_q;
  logic [WAIT_W-1:0]        wait_q;
  logic [DATA_W-1:0]        offset_q;
  logic [15:0]              unmapped_q;
  logic                     fifo_full;
  logic [CNT_W-1:0]         fifo_count;
  logic [ADDR_W+DATA_W-1:0] fifo_wdata;
  logic [DATA_W-1:0]        tx_word;

  logic       accept, ch_ok;
  logic [3:0] reg_off, ch_idx;
  logic       trig_region, wait_region, tx_region;
  logic       trig_hit, intv_hit, mask_hit, wadd_hit, off_hit, wclr_hit, tx_hit, unmapped_hit;

  assign O_cmd_ready = rdy_q && !fifo_full;
  assign accept      = I_cmd_valid && O_cmd_ready;

  assign reg_off     = I_cmd_addr[3:0];
  assign ch_idx      = I_cmd_addr[7:4];
  assign ch_ok       = int'(ch_idx) < NUM_CH;
  assign trig_region = (I_cmd_addr[ADDR_W-1:8]  == BASE_TRIG[ADDR_W-1:8]);
  assign wait_region = (I_cmd_addr[ADDR_W-1:4]  == BASE_WAIT[ADDR_W-1:4]);
  assign tx_region   = (I_cmd_addr[ADDR_W-1:12] == BASE_TX[ADDR_W-1:12]);

  assign trig_hit = accept && trig_region && ch_ok && (reg_off == OFF_TRIG);
  assign intv_hit = accept && trig_region && ch_ok && (reg_off == OFF_INTERVAL);
  assign mask_hit = accept && trig_region && ch_ok && (reg_off == OFF_MASK);
  assign wadd_hit = accept && wait_region && (reg_off == OFF_WADD);
  assign off_hit  = accept && wait_region && (reg_off == OFF_OFFSET);
  assign wclr_hit = accept && wait_region && (reg_off == OFF_WCLR);
  assign tx_hit   = accept && tx_region;
  assign unmapped_hit = accept && !(trig_hit || intv_hit || mask_hit ||
                                    wadd_hit || off_hit || wclr_hit || tx_hit);

  // TX words carry the pre-update wait value in their low WAIT_INS data bits.
  assign tx_word    = (I_cmd_data & ~INS_MASK) | (DATA_W'(wait_q) & INS_MASK);
  assign fifo_wdata = {I_cmd_addr, tx_hit ? tx_word : I_cmd_data};

  isa_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_tx_fifo (
    .I_rd_clk (I_rd_clk),
    .I_rst_n  (I_rst_n),
    .push_i   (trig_hit || tx_hit),
    .pop_i    (I_tx_ready),
    .wdata_i  (fifo_wdata),
    .rdata_o  (O_tx_data),
    .full_o   (fifo_full),
    .count_o  (fifo_count)
  );

  assign O_tx_valid = (fifo_count != '0);

  always_ff @(posedge I_rd_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      rdy_q      <= 1'b0;
      wait_q     <= '0;
      offset_q   <= '0;
      unmapped_q <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (wadd_hit)                 wait_q <= wait_q + WAIT_W'(I_cmd_data);
      else if (wclr_hit || trig_hit) wait_q <= '0;
      if (off_hit) offset_q <= I_cmd_data;
      if (unmapped_hit && unmapped_q != 16'hFFFF) unmapped_q <= unmapped_q + 16'd1;
    end
  end

  assign O_wait     = wait_q;
  assign O_offset   = offset_q;
  assign O_unmapped = unmapped_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] step_q, mask_q, cnt_q, cnt_d, rem_q, rem_d, eff_step;
    logic              trig_q, trig_d, sel;

    assign sel      = (int'(ch_idx) == c);
    assign eff_step = (step_q == '0) ? D_ONE : step_q;

    // NOTE: every next-state variable gets a default before any branch, so no
    // path through this block leaves a variable unassigned and no latch appears.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      trig_d  = 1'b0;
      if (trig_hit && sel) begin
        if (I_cmd_data == '0) begin
          state_d = SEQ_IDLE;
          cnt_d   = '0;
          rem_d   = '0;
        end else begin
          trig_d  = 1'b1;
          cnt_d   = eff_step;
          rem_d   = I_cmd_data - D_ONE;
          state_d = (I_cmd_data == D_ONE) ? SEQ_IDLE : SEQ_RUN;
        end
      end else if (state_q == SEQ_RUN) begin
        if (cnt_q == D_ONE) begin
          trig_d = 1'b1;
          cnt_d  = eff_step;
          rem_d  = rem_q - D_ONE;
          if (rem_q == D_ONE) state_d = SEQ_IDLE;
        end else begin
          cnt_d = cnt_q - D_ONE;
        end
      end
    end

    // NOTE: clocked state uses non-blocking assignments so every register in the
    // design samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge I_rd_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
        state_q <= SEQ_IDLE;
        cnt_q   <= '0;
        rem_q   <= '0;
        trig_q  <= 1'b0;
        step_q  <= '0;
        mask_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rem_q   <= rem_d;
        trig_q  <= trig_d;
        if (intv_hit && sel) step_q <= I_cmd_data;
        if (mask_hit && sel) mask_q <= I_cmd_data;
      end
    end

    assign O_trig[c]      = trig_q;
    assign O_trig_busy[c] = (state_q == SEQ_RUN);
    assign O_trig_mask[c*DATA_W +: DATA_W] = mask_q;
  end

endmodule

// File: tb/tb_isa_decode_mc.sv
// Scoreboard bench for isa_decode_mc: directed command beats queue expected TX
// words and pulse cycles; a negedge monitor pops and compares them.
module tb_isa_decode_mc;

  localparam int NUM_CH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         I_cmd_valid;
  logic         O_cmd_ready;
  logic [31:0]  I_cmd_addr, I_cmd_data;
  logic [63:0]  O_tx_data;
  logic         O_tx_valid, I_tx_ready;
  logic [3:0]   O_trig, O_trig_busy;
  logic [127:0] O_trig_mask;
  logic [31:0]  O_wait, O_offset;
  logic [15:0]  O_unmapped;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] exp_tx[$];
  int          exp_pulse[NUM_CH][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  isa_decode_mc dut (
    .I_rd_clk    (clk),
    .I_rst_n     (rst_n),
    .I_cmd_valid (I_cmd_valid),
    .O_cmd_ready (O_cmd_ready),
    .I_cmd_addr  (I_cmd_addr),
    .I_cmd_data  (I_cmd_data),
    .O_tx_data   (O_tx_data),
    .O_tx_valid  (O_tx_valid),
    .I_tx_ready  (I_tx_ready),
    .O_trig      (O_trig),
    .O_trig_mask (O_trig_mask),
    .O_trig_busy (O_trig_busy),
    .O_wait      (O_wait),
    .O_offset    (O_offset),
    .O_unmapped  (O_unmapped)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a TX word or a pulse.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    int          ec;
    if (rst_n) begin
      if (O_tx_valid && I_tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got %0h expected nothing", O_tx_data);
        end else begin
          e = exp_tx.pop_front();
          check("tx_data", O_tx_data, e);
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (O_trig[c]) begin
          if (exp_pulse[c].size() == 0) begin
            checks++; errors++;
            $display("FAIL pulse_unexpected ch%0d: got pulse at cycle %0d expected none", c, cyc);
          end else begin
            ec = exp_pulse[c].pop_front();
            check($sformatf("pulse_cycle_ch%0d", c), cyc, ec);
          end
        end
      end
    end
  end

  // Drives one beat and returns the cycle index of the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, output int acc);
    int n;
    n = 0;
    acc = -1;
    if (!clk) begin @(posedge clk); #1; end
    I_cmd_addr  = a;
    I_cmd_data  = d;
    I_cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (O_cmd_ready) begin
        @(posedge clk); #1;
        acc = cyc;
        break;
      end
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL send_timeout addr %0h: got no ready expected ready within 200 cycles", a);
        break;
      end
    end
    I_cmd_valid = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    forever begin
      @(negedge clk);
      if (cyc >= n) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int a, b, a0, a2, a3, a9, rp, na;
    logic [31:0] d;
    I_cmd_valid = 1'b0;
    I_cmd_addr  = '0;
    I_cmd_data  = '0;
    I_tx_ready  = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", O_cmd_ready, 0);
    check("rst_tx_valid", O_tx_valid, 0);
    check("rst_tx_data", O_tx_data, 0);
    check("rst_trig", {O_trig, O_trig_busy}, 0);
    check("rst_mask", O_trig_mask, 0);
    check("rst_wait_offset", {O_wait, O_offset, O_unmapped}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", O_cmd_ready, 1);

    // Pulse train ch0: step 4, N=3.
    send(32'h4000_1008, 32'hDEAD_BEEF, na);
    send(32'h4000_1004, 32'd4, na);
    exp_tx.push_back({32'h4000_1000, 32'h3});
    send(32'h4000_1000, 32'd3, a);
    exp_pulse[0].push_back(a);
    exp_pulse[0].push_back(a + 4);
    exp_pulse[0].push_back(a + 8);
    wait_neg(a + 7);
    check("busy_ch0_running", O_trig_busy[0], 1);
    wait_neg(a + 8);
    check("busy_ch0_done", O_trig_busy[0], 0);

    // Wait accumulator, TX insertion, offset and clear.
    send(32'h4000_2000, 32'h10, na);
    send(32'h4000_2000, 32'h5, na);
    @(negedge clk);
    check("wait_sum", O_wait, 32'h15);
    exp_tx.push_back({32'h4000_4010, 32'hAA00_0015});
    send(32'h4000_4010, 32'hAABB_CCDD, na);
    send(32'h4000_2004, 32'h1234, na);
    @(negedge clk);
    check("offset", O_offset, 32'h1234);
    check("wait_after_tx", O_wait, 32'h15);
    send(32'h4000_2008, 32'h0, na);
    @(negedge clk);
    check("wait_clear", O_wait, 0);

    // Backpressure: fill 8 entries, 9th must stall until the first pop.
    @(posedge clk); #1;
    I_tx_ready = 1'b0;
    for (int i = 0; i < 9; i++)
      exp_tx.push_back({32'h4000_4000 + 32'(4 * i), 32'((i + 1) << 24)});
    for (int i = 0; i < 8; i++) begin
      d = 32'((i + 1) << 24) | 32'h0012_3456;
      send(32'h4000_4000 + 32'(4 * i), d, na);
    end
    @(negedge clk);
    check("full_ready_low", O_cmd_ready, 0);
    check("full_head", {O_tx_valid, O_tx_data}, {1'b1, 32'h4000_4000, 32'h0100_0000});
    fork
      send(32'h4000_4020, 32'h0912_3456, a9);
      begin
        repeat (3) @(negedge clk);
        check("stall_ready_low", O_cmd_ready, 0);
        @(posedge clk); #1;
        I_tx_ready = 1'b1;
        rp = cyc;
      end
    join
    check("ninth_accept_cycle", a9, rp + 2);
    for (int i = 0; i < 50 && exp_tx.size() != 0; i++) @(negedge clk);
    check("fifo_drained", exp_tx.size(), 0);

    // Retrigger ch1 mid-train.
    send(32'h4000_1014, 32'd2, na);
    exp_tx.push_back({32'h4000_1010, 32'd5});
    send(32'h4000_1010, 32'd5, a);
    exp_pulse[1].push_back(a);
    exp_pulse[1].push_back(a + 2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_tx.push_back({32'h4000_1010, 32'd1});
    send(32'h4000_1010, 32'd1, b);
    exp_pulse[1].push_back(b);
    check("retrig_cycle", b, a + 3);
    @(negedge clk);
    check("retrig_idle", O_trig_busy[1], 0);
    repeat (20) @(negedge clk);

    // Concurrent channels and an N=0 trigger.
    send(32'h4000_1004, 32'd3, na);
    send(32'h4000_1024, 32'd5, na);
    send(32'h4000_1028, 32'hF0F0_F0F0, na);
    exp_tx.push_back({32'h4000_1000, 32'd2});
    send(32'h4000_1000, 32'd2, a0);
    exp_pulse[0].push_back(a0);
    exp_pulse[0].push_back(a0 + 3);
    exp_tx.push_back({32'h4000_1020, 32'd3});
    send(32'h4000_1020, 32'd3, a2);
    exp_pulse[2].push_back(a2);
    exp_pulse[2].push_back(a2 + 5);
    exp_pulse[2].push_back(a2 + 10);
    check("concurrent_b2b", a2, a0 + 1);
    exp_tx.push_back({32'h4000_1030, 32'd0});
    send(32'h4000_1030, 32'd0, a3);
    @(negedge clk);
    check("busy_concurrent", O_trig_busy, 4'b0101);
    wait_neg(a2 + 11);
    check("busy_all_idle", O_trig_busy, 4'b0000);
    check("mask_slices", O_trig_mask, {32'h0, 32'hF0F0_F0F0, 32'h0, 32'hDEAD_BEEF});

    // Unmapped accesses and wait wrap-around.
    send(32'h4000_1040, 32'd7, na);
    send(32'h4000_200C, 32'd9, na);
    @(negedge clk);
    check("unmapped_count", O_unmapped, 16'd2);
    check("unmapped_no_effect", {O_wait, O_offset, O_trig_busy}, {32'h0, 32'h1234, 4'b0});
    check("unmapped_mask", O_trig_mask, {32'h0, 32'hF0F0_F0F0, 32'h0, 32'hDEAD_BEEF});
    send(32'h4000_2000, 32'hFFFF_FFFF, na);
    send(32'h4000_2000, 32'd2, na);
    @(negedge clk);
    check("wait_wrap", O_wait, 32'd1);

    repeat (20) @(negedge clk);
    check("tx_queue_empty", exp_tx.size(), 0);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("pulse_queue_empty_ch%0d", c), exp_pulse[c].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
